// File: rtl/mwa_pkg.sv
// Shared types and helpers for the masked word assembler and its write-path companions.
package mwa_pkg;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    DONE
  } state_t;

  localparam int MWA_W = 8;

  // Popcount of a default-width mask, reusable by the write-path lane packer.
  function automatic logic [$clog2(MWA_W+1)-1:0] popcount(input logic [MWA_W-1:0] mask);
    logic [$clog2(MWA_W+1)-1:0] count;
    count = '0;
    for (int i = 0; i < MWA_W; i++) begin
      count = count + ($clog2(MWA_W+1))'(mask[i]);
    end
    return count;
  endfunction

endpackage

// File: rtl/mask_popcount.sv
// Combinational popcount of a W-bit request mask.
module mask_popcount #(
  parameter int W = 8
) (
  input  logic [W-1:0]             mask,
  output logic [$clog2(W+1)-1:0]   count
);

  localparam int CW = $clog2(W+1);

  always_comb begin
    count = '0;
    for (int i = 0; i < W; i++) begin
      count = count + CW'(mask[i]);
    end
  end

endmodule

// File: rtl/masked_word_assembler.sv
// Packs popcount(mask) bytes from the receive stream into byte slots 0.. of a word,
// then presents the word with its mask; aborts with an ERR pulse on inter-byte timeout.
module masked_word_assembler
  import mwa_pkg::*;
#(
  parameter int W        = 8,
  parameter int BYTE_BIT = 8,
  parameter int TIMEOUT  = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [W-1:0]          mask_in,
  input  logic                  mask_valid,
  output logic                  mask_ready,
  input  logic [BYTE_BIT-1:0]   rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic [W*BYTE_BIT-1:0] mem_out,
  output logic [W-1:0]          mask_out,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  err
);

  localparam int CW = $clog2(W+1);
  localparam int TW = $clog2(TIMEOUT+1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT-1);

  state_t                  state_q, state_d;
  logic [W*BYTE_BIT-1:0]   mem_q, mem_d;
  logic [W-1:0]            mask_q, mask_d;
  logic [CW-1:0]           idx_q, idx_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [TW-1:0]           timer_q, timer_d;
  logic                    err_q, err_d;
  logic [CW-1:0]           mask_count;

  logic mask_accept;
  logic rx_accept;
  logic last_byte;
  logic timer_expired;

  mask_popcount #(
    .W (W)
  ) u_mask_popcount (
    .mask  (mask_in),
    .count (mask_count)
  );

  assign mask_accept   = (state_q == IDLE) && mask_valid;
  assign rx_accept     = (state_q == COLLECT) && rx_valid;
  assign last_byte     = (idx_q == cnt_q - CW'(1));
  assign timer_expired = (timer_q == TIMER_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mem_q   <= '0;
      mask_q  <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      timer_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mem_q   <= mem_d;
      mask_q  <= mask_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      timer_q <= timer_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (mask_valid) begin
          state_d = (mask_count == '0) ? DONE : COLLECT;
        end
      end
      COLLECT: begin
        // A byte arriving on the expiry cycle takes priority over the abort.
        if (rx_valid) begin
          if (last_byte) begin
            state_d = DONE;
          end
        end else if (timer_expired) begin
          state_d = IDLE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_d   = mem_q;
    mask_d  = mask_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    timer_d = timer_q;
    err_d   = 1'b0;
    if (mask_accept) begin
      mask_d  = mask_in;
      mem_d   = '0;
      idx_d   = '0;
      cnt_d   = mask_count;
      timer_d = '0;
    end else if (rx_accept) begin
      for (int k = 0; k < W; k++) begin
        if (idx_q == CW'(k)) begin
          mem_d[k*BYTE_BIT +: BYTE_BIT] = rx_data;
        end
      end
      idx_d   = idx_q + CW'(1);
      timer_d = '0;
    end else if (state_q == COLLECT) begin
      if (timer_expired) begin
        err_d   = 1'b1;
        timer_d = '0;
      end else begin
        timer_d = timer_q + TW'(1);
      end
    end
  end

  always_comb begin
    mask_ready = (state_q == IDLE);
    rx_ready   = (state_q == COLLECT);
    out_valid  = (state_q == DONE);
    mem_out    = mem_q;
    mask_out   = mask_q;
    err        = err_q;
  end

endmodule

// File: tb/tb_masked_word_assembler.sv
// Directed bench: table of whole transactions plus hand sequences for hold, timeout,
// mid-transfer reset and byte-on-expiry corner cases.
module tb_masked_word_assembler;

  logic        clk = 1'b0;
  logic        rst_n;
  always #5 clk = ~clk;

  logic [7:0]  mask_in, rx_data, mask_out;
  logic        mask_valid, mask_ready, rx_valid, rx_ready, out_valid, out_ready, err;
  logic [63:0] mem_out;

  logic [7:0]  mask_in4, rx_data4, mask_out4;
  logic        mask_valid4, mask_ready4, rx_valid4, rx_ready4, out_valid4, out_ready4, err4;
  logic [63:0] mem_out4;

  int checks = 0;
  int errors = 0;
  int err_pulses = 0;
  int err4_pulses = 0;

  masked_word_assembler #(.W(8), .BYTE_BIT(8), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .mask_in(mask_in), .mask_valid(mask_valid), .mask_ready(mask_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .mem_out(mem_out), .mask_out(mask_out), .out_valid(out_valid),
    .out_ready(out_ready), .err(err)
  );

  masked_word_assembler #(.W(8), .BYTE_BIT(8), .TIMEOUT(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .mask_in(mask_in4), .mask_valid(mask_valid4), .mask_ready(mask_ready4),
    .rx_data(rx_data4), .rx_valid(rx_valid4), .rx_ready(rx_ready4),
    .mem_out(mem_out4), .mask_out(mask_out4), .out_valid(out_valid4),
    .out_ready(out_ready4), .err(err4)
  );

  // err changes in the NBA region, so sampling at posedge sees last cycle's value.
  always @(posedge clk) begin
    if (err)  err_pulses++;
    if (err4) err4_pulses++;
  end

  typedef struct {
    logic [7:0]  mask;
    int          n;
    int          gap;
    logic [63:0] data;
    logic [63:0] exp_mem;
  } vec_t;

  vec_t vecs [4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send_mask(input logic [7:0] m);
    int n = 0;
    mask_in    = m;
    mask_valid = 1'b1;
    while (!mask_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("mask_accept", {63'd0, mask_ready}, 64'd1);
    @(negedge clk);
    mask_valid = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n = 0;
    repeat (gap) @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("byte_accept", {63'd0, rx_ready}, 64'd1);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("consume_out_valid_low", {63'd0, out_valid}, 64'd0);
    check("consume_mask_ready", {63'd0, mask_ready}, 64'd1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int pulses;
    int pulse_at;
    bit saw_ov;

    vecs[0] = '{8'hA5, 4, 0, 64'h0000_0000_4433_2211, 64'h0000_0000_4433_2211};
    vecs[1] = '{8'h00, 0, 0, 64'h0,                   64'h0};
    vecs[2] = '{8'h81, 2, 1, 64'h0000_0000_0000_ADDE, 64'h0000_0000_0000_ADDE};
    vecs[3] = '{8'hFF, 8, 0, 64'hF7F6_F5F4_F3F2_F1F0, 64'hF7F6_F5F4_F3F2_F1F0};

    rst_n = 1'b0;
    mask_in = '0; mask_valid = 1'b0; rx_data = '0; rx_valid = 1'b0; out_ready = 1'b0;
    mask_in4 = '0; mask_valid4 = 1'b0; rx_data4 = '0; rx_valid4 = 1'b0; out_ready4 = 1'b0;

    @(negedge clk);
    check("reset_mask_ready", {63'd0, mask_ready}, 64'd1);
    check("reset_rx_ready", {63'd0, rx_ready}, 64'd0);
    check("reset_out_valid", {63'd0, out_valid}, 64'd0);
    check("reset_err", {63'd0, err}, 64'd0);
    check("reset_mem", mem_out, 64'd0);
    check("reset_mask_out", {56'd0, mask_out}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      send_mask(vecs[i].mask);
      for (int k = 0; k < vecs[i].n; k++) begin
        send_byte(vecs[i].data[k*8 +: 8], vecs[i].gap);
      end
      check($sformatf("vec%0d_out_valid", i), {63'd0, out_valid}, 64'd1);
      check($sformatf("vec%0d_rx_ready", i), {63'd0, rx_ready}, 64'd0);
      check($sformatf("vec%0d_mem", i), mem_out, vecs[i].exp_mem);
      check($sformatf("vec%0d_mask_out", i), {56'd0, mask_out}, {56'd0, vecs[i].mask});
      consume();
    end

    // Full mask with gaps, then back-pressure while a new mask waits.
    send_mask(8'hFF);
    for (int k = 1; k <= 8; k++) send_byte(8'(k), 3);
    mask_in    = 8'h01;
    mask_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      check("hold_out_valid", {63'd0, out_valid}, 64'd1);
      check("hold_mem", mem_out, 64'h0807_0605_0403_0201);
      check("hold_mask_out", {56'd0, mask_out}, 64'hFF);
      check("hold_mask_ready", {63'd0, mask_ready}, 64'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("handoff_out_valid", {63'd0, out_valid}, 64'd0);
    check("handoff_mask_ready", {63'd0, mask_ready}, 64'd1);
    @(negedge clk);
    mask_valid = 1'b0;
    check("handoff_collect", {63'd0, rx_ready}, 64'd1);
    check("handoff_mask_out", {56'd0, mask_out}, 64'h01);
    check("handoff_mem_cleared", mem_out, 64'd0);
    send_byte(8'h77, 0);
    check("handoff_mem", mem_out, 64'h77);
    consume();

    // Inter-byte timeout: ERR exactly once, 16 cycles after the accept.
    send_mask(8'h03);
    send_byte(8'hAB, 0);
    pulses = 0; pulse_at = -1; saw_ov = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (err) begin
        pulses++;
        pulse_at = k;
      end
      if (out_valid) saw_ov = 1'b1;
    end
    check("timeout_pulses", 64'(pulses), 64'd1);
    check("timeout_cycle", 64'(pulse_at), 64'd16);
    check("timeout_no_out_valid", {63'd0, saw_ov}, 64'd0);
    check("timeout_idle", {63'd0, mask_ready}, 64'd1);
    check("timeout_rx_ready", {63'd0, rx_ready}, 64'd0);
    check("timeout_partial_mem", mem_out, 64'hAB);
    check("timeout_mask_out", {56'd0, mask_out}, 64'h03);

    // Asynchronous reset in the middle of a collection.
    send_mask(8'h0F);
    send_byte(8'hC1, 0);
    send_byte(8'hC2, 0);
    #2 rst_n = 1'b0;
    #1;
    check("areset_mem", mem_out, 64'd0);
    check("areset_mask_out", {56'd0, mask_out}, 64'd0);
    check("areset_rx_ready", {63'd0, rx_ready}, 64'd0);
    check("areset_mask_ready", {63'd0, mask_ready}, 64'd1);
    check("areset_out_valid", {63'd0, out_valid}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_mask(8'h01);
    send_byte(8'h5A, 0);
    check("post_reset_out_valid", {63'd0, out_valid}, 64'd1);
    check("post_reset_mem", mem_out, 64'h5A);
    consume();

    // TIMEOUT=4 instance: each byte lands exactly on the would-be expiry edge.
    mask_in4 = 8'h07;
    mask_valid4 = 1'b1;
    check("exp_mask_ready", {63'd0, mask_ready4}, 64'd1);
    @(negedge clk);
    mask_valid4 = 1'b0;
    rx_data4 = 8'h10;
    rx_valid4 = 1'b1;
    check("exp_rx_ready0", {63'd0, rx_ready4}, 64'd1);
    @(negedge clk);
    rx_valid4 = 1'b0;
    repeat (3) @(negedge clk);
    rx_data4 = 8'h20;
    rx_valid4 = 1'b1;
    check("exp_rx_ready1", {63'd0, rx_ready4}, 64'd1);
    @(negedge clk);
    rx_valid4 = 1'b0;
    repeat (3) @(negedge clk);
    rx_data4 = 8'h30;
    rx_valid4 = 1'b1;
    check("exp_rx_ready2", {63'd0, rx_ready4}, 64'd1);
    @(negedge clk);
    rx_valid4 = 1'b0;
    check("exp_out_valid", {63'd0, out_valid4}, 64'd1);
    check("exp_mem", mem_out4, 64'h0030_2010);
    check("exp_mask_out", {56'd0, mask_out4}, 64'h07);
    out_ready4 = 1'b1;
    @(negedge clk);
    out_ready4 = 1'b0;
    check("exp_released", {63'd0, out_valid4}, 64'd0);

    repeat (2) @(negedge clk);
    check("exp_no_err", 64'(err4_pulses), 64'd0);
    check("total_err_pulses", 64'(err_pulses), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
